// File: rtl/fifo_burst_reader_if.sv
// Valid/ready output stream of the FIFO burst reader.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// Drain stage for the synchronous FIFO: pulls bursts of up to BURST_LEN words
// on threshold or idle timeout and replays them on a valid/ready stream with a
// per-burst last marker. A 2-entry skid buffer absorbs the 1-cycle read latency.
module fifo_burst_reader #(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 16,
    parameter int  BURST_LEN  = 4,
    parameter int  TIMEOUT    = 64,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic                  thr_trig,
    input  logic [CW-1:0]         count,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd,
    output logic                  busy,
    fifo_burst_reader_if.master   m
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         beats_left, beats_nxt;
    logic [TW-1:0]         tmo_cnt, tmo_nxt;
    logic                  inflight, inflight_last;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic                  l0, l1;
    logic                  pop;
    logic [CW-1:0]         burst_len;
    logic [2:0]            slots;

    // Length captured at burst start; later upstream writes do not extend it.
    assign burst_len = (count > CW'(BURST_LEN)) ? CW'(BURST_LEN) : count;

    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = d0;
    assign m.m_last  = l0;
    assign pop       = (occ != 2'd0) && m.m_ready;
    assign busy      = (state != IDLE);

    // Buffer occupancy after this cycle, counting the word already in flight.
    assign slots = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Next-state, burst bookkeeping and the read strobe.
    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        tmo_nxt   = tmo_cnt;
        rd        = 1'b0;
        case (state)
            IDLE: begin
                if (thr_trig) begin
                    state_nxt = BURST;
                    beats_nxt = burst_len;
                    tmo_nxt   = '0;
                end else if (!empty) begin
                    // The cycle on which the counter would reach TIMEOUT-1
                    // launches the flush burst.
                    if (tmo_cnt == TW'(TIMEOUT - 2)) begin
                        state_nxt = BURST;
                        beats_nxt = burst_len;
                        tmo_nxt   = '0;
                    end else begin
                        tmo_nxt = tmo_cnt + TW'(1);
                    end
                end else begin
                    tmo_nxt = '0;
                end
            end
            BURST: begin
                if (beats_left == '0) begin
                    state_nxt = DRAIN;
                end else if (!empty && slots < 3'd2) begin
                    // empty with beats left is an upstream protocol error:
                    // hold here without reading.
                    rd        = 1'b1;
                    beats_nxt = beats_left - CW'(1);
                    if (beats_left == CW'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, burst counter and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beats_left <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    // Read-latency tracker: data_out is valid the cycle after rd, with its tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd;
            inflight_last <= rd && (beats_left == CW'(1));
        end
    end

    // Two-entry in-order skid buffer; head entry d0/l0 drives the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= 2'd0;
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        d0 <= data_out;
                        l0 <= inflight_last;
                    end else begin
                        d1 <= data_out;
                        l1 <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    l0  <= l1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        d0 <= data_out;
                        l0 <= inflight_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= data_out;
                        l1 <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO upstream, scoreboard of
// expected beats, and a negedge monitor that checks every delivered beat.
module tb_fifo_burst_reader;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BL    = 4;
    localparam int TMO   = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty, thr_trig, rd, busy;
    logic [CW-1:0] count;
    logic [DW-1:0] data_out = '0;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) sif ();

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .empty(empty), .thr_trig(thr_trig), .count(count),
        .data_out(data_out), .rd(rd), .busy(busy), .m(sif.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO model
    logic [DW-1:0] fmem [0:31];
    int            wp = 0, rp = 0, fcnt, trig_level = 99;
    logic          wr = 1'b0;
    logic [DW-1:0] wdata = '0;

    always_comb fcnt = wp - rp;
    assign count    = CW'(fcnt);
    assign empty    = (fcnt == 0);
    assign thr_trig = (fcnt >= trig_level);

    always @(posedge clk) begin
        if (wr) begin
            fmem[wp[4:0]] <= wdata;
            wp <= wp + 1;
        end
        if (rd && fcnt != 0) begin
            data_out <= fmem[rp[4:0]];
            rp <= rp + 1;
        end
    end

    // Scoreboard and bookkeeping
    beat_t sbq[$];
    int    rd_log[$], pop_log[$];
    int    n_checks = 0, n_fail = 0, n_pops = 0;
    int    ne_stamp = 0, idle_stamp = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor
    logic          prev_stall = 1'b0, last_popped = 1'b0, was_empty = 1'b1, was_busy = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    beat_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            last_popped = 1'b0;
        end else begin
            if (last_popped) chk("busy_after_last", busy, 1'b0);
            last_popped = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", sif.m_valid, 1'b1);
                chk("hold_data", sif.m_data, prev_d);
                chk("hold_last", sif.m_last, prev_l);
            end
            if (rd) begin
                chk("rd_not_empty", empty, 1'b0);
                rd_log.push_back(cyc);
            end
            if (sif.m_valid && sif.m_ready) begin
                n_pops++;
                pop_log.push_back(cyc);
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", sif.m_data, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("m_data", sif.m_data, mon_e.d);
                    chk("m_last", sif.m_last, mon_e.l);
                    if (mon_e.l) last_popped = 1'b1;
                end
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_d     = sif.m_data;
            prev_l     = sif.m_last;
        end
        if (was_empty && !empty) ne_stamp = cyc;
        if (was_busy && !busy) idle_stamp = cyc;
        was_empty = empty;
        was_busy  = busy;
    end

    // Stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            wr    = 1'b1;
            wdata = base + DW'(i);
        end
        step();
        wr = 1'b0;
    endtask

    task automatic expect_burst(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.d = base + DW'(i);
            b.l = (i == n - 1);
            sbq.push_back(b);
        end
    endtask

    task automatic wait_idle(input string name, input int maxc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            step();
            if (sbq.size() == 0 && fcnt == 0 && !busy && !sif.m_valid) done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic wait_rd(input string name, input int target, input int maxc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            step();
            if (rd_log.size() >= target) done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, pb;
        logic ok;
        sif.m_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_rd", rd, 1'b0);
        chk("rst_valid", sif.m_valid, 1'b0);
        chk("rst_last", sif.m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", sif.m_data, 8'h00);
        rst = 1'b0;
        step();

        // 1: reset mid-burst after two of four beats
        trig_level = 99;
        write_n(8'hB0, 8);
        expect_burst(8'hB0, 4);
        pb = n_pops;
        trig_level = 4;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (n_pops >= pb + 2) ok = 1'b1;
        end
        chk("t1_two_beats", ok, 1'b1);
        chk("t1_pre_valid", sif.m_valid, 1'b1);
        chk("t1_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t1_rst_rd", rd, 1'b0);
        chk("t1_rst_valid", sif.m_valid, 1'b0);
        chk("t1_rst_last", sif.m_last, 1'b0);
        chk("t1_rst_busy", busy, 1'b0);
        sbq.delete();
        step();
        step();
        chk("t1_fifo_left", fcnt, 4);
        expect_burst(8'hB4, 4);
        rst = 1'b0;
        wait_idle("t1_idle", 100);

        // 2: threshold bursts from 10 words, full rate
        trig_level = 99;
        write_n(8'hA0, 10);
        expect_burst(8'hA0, 4);
        expect_burst(8'hA4, 4);
        expect_burst(8'hA8, 2);
        rb = rd_log.size();
        pb = pop_log.size();
        trig_level = 4;
        wait_idle("t2_idle", 300);
        chk("t2_rd_total", rd_log.size() - rb, 10);
        if (rd_log.size() >= rb + 4 && pop_log.size() >= pb + 4) begin
            chk("t2_rd_consec", rd_log[rb + 3] - rd_log[rb], 3);
            chk("t2_first_lat", pop_log[pb] - rd_log[rb], 2);
            chk("t2_pop_consec", pop_log[pb + 3] - pop_log[pb], 3);
        end

        // 3: backpressure
        trig_level = 99;
        sif.m_ready = 1'b0;
        write_n(8'hC0, 4);
        expect_burst(8'hC0, 4);
        rb = rd_log.size();
        pb = pop_log.size();
        trig_level = 4;
        repeat (10) step();
        chk("t3_rd_count", rd_log.size() - rb, 2);
        chk("t3_valid", sif.m_valid, 1'b1);
        chk("t3_head", sif.m_data, 8'hC0);
        chk("t3_busy", busy, 1'b1);
        sif.m_ready = 1'b1;
        wait_idle("t3_idle", 50);
        chk("t3_pops", pop_log.size() - pb, 4);
        for (int i = pb + 1; i < pop_log.size(); i++)
            chk("t3_gap", (pop_log[i] - pop_log[i - 1]) <= 2, 1'b1);

        // 4: timeout flush of 3 words
        trig_level = 99;
        rb = rd_log.size();
        expect_burst(8'hD0, 3);
        write_n(8'hD0, 3);
        wait_rd("t4_rd_seen", rb + 3, 150);
        if (rd_log.size() > rb) chk("t4_tmo_delay", rd_log[rb] - ne_stamp, 63);
        wait_idle("t4_idle", 50);
        chk("t4_empty", empty, 1'b1);

        // 5: threshold and timeout in the same cycle
        trig_level = 99;
        rb = rd_log.size();
        expect_burst(8'hE0, 4);
        expect_burst(8'hE4, 1);
        write_n(8'hE0, 5);
        while (cyc < ne_stamp + 62) step();
        trig_level = 2;
        wait_rd("t5_rd_seen", rb + 5, 200);
        if (rd_log.size() >= rb + 5) begin
            chk("t5_tie_delay", rd_log[rb] - ne_stamp, 63);
            chk("t5_tmo_cleared", rd_log[rb + 4] - idle_stamp, 63);
        end
        wait_idle("t5_idle", 50);

        // 6: writes during a burst do not lengthen it
        trig_level = 99;
        write_n(8'h60, 4);
        expect_burst(8'h60, 4);
        expect_burst(8'h64, 3);
        trig_level = 4;
        write_n(8'h64, 3);
        wait_idle("t6_idle", 300);
        chk("t6_sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drain stage that sits directly downstream of the synchronous FIFO.
- Watches the FIFO's `thr_trig`, `empty` and `count` outputs and issues `rd` pulses to pull bursts of up to BURST_LEN words.
- Repackages those words onto a valid/ready stream with a per-burst `m_last` marker.
- A timeout flushes partial data that sits below threshold too long.
- It never reads an empty FIFO, so it can never cause FIFO underflow.

Parameters:
- DATA_WIDTH, 8: width of FIFO read data and of `m_data`.
- FIFO_DEPTH, 16: depth of the upstream FIFO. `count` width is CW = $clog2(FIFO_DEPTH)+1.
- BURST_LEN, 4: maximum beats per burst, range 1..FIFO_DEPTH.
- TIMEOUT, 64: idle cycles with data present but below threshold before a flush burst starts. Must be ≥ 2.

Ports:
- `clk` in 1: clock, all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `empty` in 1: FIFO empty flag.
- `thr_trig` in 1: FIFO threshold trigger (count ≥ trig_level).
- `count` in CW: FIFO occupancy.
- `data_out` in DATA_WIDTH: FIFO read data, valid the cycle after `rd` is sampled high.
- `rd` out 1: FIFO read strobe, one word per high cycle.
- `m_data` out DATA_WIDTH: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: final beat of the current burst.
- `busy` out 1: high in any state other than IDLE.

Behaviour:
- **Reset.** `rst` high asynchronously clears all state:
  - `rd`, `m_valid`, `m_last`, `busy` = 0; `m_data` = 0.
  - state = IDLE; beats_left = 0; timeout counter = 0.
  - Skid buffer emptied; in-flight read discarded.
  - Reset mid-burst drops any partially delivered burst with no `m_last`.
- **Read latency and in-flight tracking.** Read latency is fixed at 1. A 1-bit inflight flag is registered from `rd`. When inflight is 1, `data_out` plus its last tag is pushed into the skid buffer that cycle.
- **Skid buffer.**
  - 2 entries, FIFO-ordered, occupancy `occ` in 0..2. `m_data`/`m_last` always come from the head entry.
  - `m_valid` = (`occ` != 0), registered-path only; there is no combinational path from `data_out` to `m_valid`.
  - pop = `m_valid` && `m_ready`.
  - Once `m_valid` is high, `m_data`/`m_last` stay stable until pop.
- **`rd` rule (combinational).**
  - `rd` = (state == BURST) && (beats_left != 0) && !`empty` && (`occ` + inflight − pop < 2).
  - Sustains 1 beat/cycle while `m_ready` = 1.
- **Beat tagging.** Each issued read is tagged last = (beats_left == 1). beats_left decrements on every `rd`.
- **IDLE:**
  - If `thr_trig` = 1: go to BURST; beats_left = min(BURST_LEN, `count`); clear the timeout counter.
  - Else if !`empty`: increment the timeout counter. On reaching TIMEOUT−1, next cycle go to BURST with beats_left = min(BURST_LEN, `count`), clear the counter.
  - Else (`empty`): clear the timeout counter.
  - `thr_trig` has priority over timeout when both occur in the same cycle.
- **BURST.** Issue reads per the `rd` rule. When beats_left reaches 0 (after the final `rd`), go to DRAIN.
- **`empty` during BURST.** This block is the FIFO's only reader, so words counted at burst start remain available. If `empty` is high with beats_left != 0, `rd` is held low and the state is held. That condition is a protocol error; the bench flags it.
- **DRAIN.** Wait until inflight == 0 and (`occ` == 0, or `occ` == 1 with pop this cycle), then go to IDLE. A new burst can start at the earliest on the cycle after returning to IDLE.
- **Upstream writes.** Writes during a burst do not change beats_left; the captured length is fixed.
- **Burst length bounds.** `count` = 0 never starts a burst, since `thr_trig`/timeout need non-empty. Burst length is always 1..BURST_LEN, with exactly one `m_last` per burst, on its final beat.
- **Backpressure.** With `m_ready` held low, at most 2 words are buffered and `rd` stops; no data is lost or duplicated.

Test Plan:
1. Reset: pulse `rst` mid-burst (beats 2 of 4 delivered) → `rd`/`m_valid`/`busy` drop asynchronously. After release, state is IDLE and the next burst starts cleanly with a full 4-beat length.
2. Threshold burst: FIFO holds 10 words (A0..A9), `thr_trig` = 1, `m_ready` = 1 → `rd` high 4 consecutive cycles. `m_data` = A0..A3 on 4 consecutive cycles starting 2 cycles after the first `rd`. `m_last` only with A3. `busy` falls after A3 pops.
3. Backpressure: same as 2 with `m_ready` = 0 → exactly 2 `rd` pulses, `m_valid` = 1 holding A0. Raise `m_ready` → A0..A3 delivered in order, no gaps beyond 1 cycle, no duplicates.
4. Timeout flush: 3 words written, `thr_trig` = 0, TIMEOUT = 64 → no `rd` for 63 cycles. Then a 3-beat burst with `m_last` on beat 3; FIFO `empty` afterwards, no underflow.
5. Threshold vs. timeout tie: `thr_trig` rises on the same cycle the timeout expires → single burst of min(4, `count`) beats, timeout counter cleared.
6. Writes during burst: `count` = 4 at burst start and 3 more written mid-burst → burst is exactly 4 beats. A second burst follows per `thr_trig`/timeout.
